// File: rtl/cache_pkg.sv
// Shared definitions for the cache-side memory port and the cache fill FSM.
package cache_pkg;

    // Word width of the backing store and of the cache data paths.
    localparam int WORD_W = 16;

    // Byte address width seen by the caches.
    localparam int ADDR_W = 16;

    // Cycles from a read grant to the returned word being consumed.
    localparam int READ_LATENCY = 4;

    // Arbiter / fill states. The encoding is shared with cache_fill_fsm.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        D_READ  = 2'd1,
        I_READ  = 2'd2,
        D_WRITE = 2'd3
    } state_t;

    // Latency counter value on which a read completes.
    // The counter is 0 in the cycle after the grant edge. The memory has a
    // registered read, so the word is ready well before this edge.
    localparam logic [1:0] CNT_LAST = 2'(READ_LATENCY - 2);

endpackage

// File: rtl/multicycle_memory.sv
// Single-port word memory. Writes are synchronous. Reads are registered and
// read-first, so the result appears one edge after the address.
module multicycle_memory
    import cache_pkg::*;
#(
    parameter int MEM_WORDS = 32768,
    parameter int IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    // The backing store is zero at configuration / simulation start and is
    // never cleared afterwards. Reset does not touch it.
    logic [WORD_W-1:0] mem_array [0:MEM_WORDS-1] = '{default: '0};

    logic [WORD_W-1:0] rdata_reg;

    // Synchronous write and registered read-first access on the single port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_array[addr] <= wdata;
        end
        rdata_reg <= mem_array[addr];
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/cache_to_mem.sv
// Arbitrates the data-cache and instruction-cache requests onto one backing
// memory.
// - A data request wins a tie with an instruction request.
// - A read returns its word after a fixed 4-cycle latency.
// - A write commits on the grant edge and is acknowledged in the next cycle.
module cache_to_mem
    import cache_pkg::*;
#(
    parameter int MEM_WORDS = 32768     // backing depth in words, at most 32768
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              d_enable,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [WORD_W-1:0] d_data,
    input  logic              i_enable,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              d_valid,
    output logic              i_valid,
    output logic [WORD_W-1:0] data_out
);

    localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    state_t            state_reg;
    logic [1:0]        cnt_reg;
    logic [IDX_W-1:0]  addr_reg;
    logic              d_valid_reg;
    logic              i_valid_reg;
    logic [WORD_W-1:0] data_reg;

    logic [14:0]       d_word;
    logic [14:0]       i_word;
    logic [IDX_W-1:0]  d_idx;
    logic [IDX_W-1:0]  i_idx;
    logic              write_grant;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_addr;
    logic [WORD_W-1:0] mem_rdata;
    logic              unused_bits;

    // Byte addresses are converted to word indices. Bit 0 selects a byte
    // within a word and is ignored.
    assign d_word = d_addr[15:1];
    assign i_word = i_addr[15:1];
    assign d_idx  = d_word[IDX_W-1:0];
    assign i_idx  = i_word[IDX_W-1:0];
    assign unused_bits = ^{d_addr, i_addr};

    // A write is issued to the memory on the same edge that grants it. That
    // edge therefore uses the live request address and data, which are the
    // values present at grant.
    assign write_grant = (state_reg == IDLE) && d_enable && d_write && !rst;
    assign mem_we      = write_grant;
    assign mem_addr    = write_grant ? d_idx : addr_reg;

    multicycle_memory #(
        .MEM_WORDS (MEM_WORDS),
        .IDX_W     (IDX_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (d_data),
        .rdata (mem_rdata)
    );

    // Arbiter FSM with latency counter and registered completion outputs.
    //
    // Read granted at edge t0:
    // - valid and data_out are loaded at t0+3.
    // - The state returns to IDLE on that same edge, so the edge at t0+4
    //   can already grant the next request (one word per 4 cycles).
    //
    // Write granted at t0:
    // - The acknowledgement covers t0..t0+1.
    // - The state is IDLE from t0+1.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= 2'd0;
            addr_reg    <= '0;
            d_valid_reg <= 1'b0;
            i_valid_reg <= 1'b0;
            data_reg    <= '0;
        end else begin
            d_valid_reg <= 1'b0;
            i_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    cnt_reg <= 2'd0;
                    if (d_enable) begin
                        addr_reg <= d_idx;
                        if (d_write) begin
                            state_reg   <= D_WRITE;
                            d_valid_reg <= 1'b1;
                        end else begin
                            state_reg <= D_READ;
                        end
                    end else if (i_enable) begin
                        addr_reg  <= i_idx;
                        state_reg <= I_READ;
                    end
                end
                D_READ, I_READ: begin
                    if (cnt_reg == CNT_LAST) begin
                        cnt_reg   <= 2'd0;
                        state_reg <= IDLE;
                        data_reg  <= mem_rdata;
                        if (state_reg == D_READ) begin
                            d_valid_reg <= 1'b1;
                        end else begin
                            i_valid_reg <= 1'b1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 2'd1;
                    end
                end
                D_WRITE: begin
                    cnt_reg   <= 2'd0;
                    state_reg <= IDLE;
                end
                default: begin
                    cnt_reg   <= 2'd0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign d_valid  = d_valid_reg;
    assign i_valid  = i_valid_reg;
    assign data_out = data_reg;

endmodule

// File: tb/tb_cache_to_mem.sv
// Directed testbench for cache_to_mem. The expected values are worked out
// by hand.
module tb_cache_to_mem;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        d_enable = 1'b0;
    logic        d_write = 1'b0;
    logic [15:0] d_addr = 16'h0;
    logic [15:0] d_data = 16'h0;
    logic        i_enable = 1'b0;
    logic [15:0] i_addr = 16'h0;
    logic        d_valid;
    logic        i_valid;
    logic [15:0] data_out;

    int total = 0;
    int bad = 0;
    int d_pulses = 0;
    int i_pulses = 0;
    bit both_seen = 1'b0;

    cache_to_mem #(.MEM_WORDS(32768)) dut (
        .clk      (clk),
        .rst      (rst),
        .d_enable (d_enable),
        .d_write  (d_write),
        .d_addr   (d_addr),
        .d_data   (d_data),
        .i_enable (i_enable),
        .i_addr   (i_addr),
        .d_valid  (d_valid),
        .i_valid  (i_valid),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    // Count completion pulses mid-cycle and record any overlap.
    always @(negedge clk) begin
        if (d_valid === 1'b1) d_pulses++;
        if (i_valid === 1'b1) i_pulses++;
        if (d_valid === 1'b1 && i_valid === 1'b1) both_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance past one rising edge; registered outputs are settled at return.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Step edges until the selected valid is high. The result is the number
    // of edges taken, capped at 20 on timeout.
    task automatic wait_valid(input bit want_d, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(want_d ? d_valid : i_valid) && n < 20);
    endtask

    // Issue an instruction read, check its 4-edge latency and returned word.
    task automatic i_read(input logic [15:0] a, input logic [15:0] exp, input string tag);
        int n;
        i_enable = 1'b1;
        i_addr   = a;
        wait_valid(1'b0, n);
        i_enable = 1'b0;
        check({tag, "_lat"}, n, 4);
        check({tag, "_data"}, data_out, exp);
        check({tag, "_dv"}, d_valid, 0);
        $display("txn i_read addr=%h data=%h lat=%0d", a, data_out, n);
    endtask

    // Issue a data write, check the one-cycle acknowledge after grant.
    task automatic d_write_op(input logic [15:0] a, input logic [15:0] v, input string tag);
        logic [15:0] held;
        held     = data_out;
        d_enable = 1'b1;
        d_write  = 1'b1;
        d_addr   = a;
        d_data   = v;
        tick();
        d_enable = 1'b0;
        d_write  = 1'b0;
        d_data   = 16'hDEAD;
        check({tag, "_dv"}, d_valid, 1);
        check({tag, "_hold"}, data_out, held);
        tick();
        check({tag, "_dv_off"}, d_valid, 0);
        $display("txn d_write addr=%h data=%h", a, v);
    endtask

    logic [15:0] wr_addr [3] = '{16'h0000, 16'h0002, 16'h0004};
    logic [15:0] wr_val  [3] = '{16'h000F, 16'h000E, 16'h000D};

    initial begin
        int n;
        int snap;

        // Reset, then ten quiet cycles.
        tick();
        tick();
        rst = 1'b0;
        check("rst_dv", d_valid, 0);
        check("rst_iv", i_valid, 0);
        check("rst_data", data_out, 0);
        for (int k = 0; k < 10; k++) tick();
        check("idle_dv", d_valid, 0);
        check("idle_iv", i_valid, 0);
        check("idle_data", data_out, 0);
        check("idle_pulses", d_pulses + i_pulses, 0);
        $display("txn idle 10 cycles");

        // Instruction block fill of 8 words from zeroed memory. The address
        // advances on each valid, and every fill takes 4 edges.
        i_enable = 1'b1;
        for (int k = 0; k < 8; k++) begin
            i_addr = 16'(2 * k);
            wait_valid(1'b0, n);
            check("fill_lat", n, 4);
            check("fill_data", data_out, 0);
            check("fill_dv", d_valid, 0);
            $display("txn fill addr=%h data=%h lat=%0d", i_addr, data_out, n);
        end
        i_enable = 1'b0;
        tick();
        check("fill_count", i_pulses, 8);
        check("fill_no_d", d_pulses, 0);

        // Three writes, then read them back through the instruction port.
        for (int k = 0; k < 3; k++) d_write_op(wr_addr[k], wr_val[k], "wr");
        for (int k = 0; k < 3; k++) i_read(wr_addr[k], wr_val[k], "rb");

        // data_out holds its last value while idle.
        for (int k = 0; k < 5; k++) tick();
        check("hold_data", data_out, 16'h000D);

        // Simultaneous requests: the data read wins, then the instruction read
        // completes 4 cycles later.
        d_enable = 1'b1;
        d_write  = 1'b0;
        d_addr   = 16'h0002;
        i_enable = 1'b1;
        i_addr   = 16'h0004;
        wait_valid(1'b1, n);
        d_enable = 1'b0;
        check("pri_d_lat", n, 4);
        check("pri_d_data", data_out, 16'h000E);
        check("pri_d_iv", i_valid, 0);
        $display("txn d_read addr=0002 data=%h", data_out);
        wait_valid(1'b0, n);
        i_enable = 1'b0;
        check("pri_i_lat", n, 4);
        check("pri_i_data", data_out, 16'h000D);
        $display("txn i_read addr=0004 data=%h", data_out);

        // A write raised while an I read is in flight waits for IDLE.
        i_enable = 1'b1;
        i_addr   = 16'h0000;
        tick();
        i_enable = 1'b0;
        d_enable = 1'b1;
        d_write  = 1'b1;
        d_addr   = 16'h0006;
        d_data   = 16'h1234;
        tick();
        check("busy_dv1", d_valid, 0);
        tick();
        check("busy_dv2", d_valid, 0);
        tick();
        check("busy_iv", i_valid, 1);
        check("busy_idata", data_out, 16'h000F);
        check("busy_dv3", d_valid, 0);
        tick();
        d_enable = 1'b0;
        d_write  = 1'b0;
        check("busy_wr_dv", d_valid, 1);
        check("busy_wr_iv", i_valid, 0);
        check("busy_wr_hold", data_out, 16'h000F);
        $display("txn deferred d_write addr=0006 data=1234");
        tick();
        i_read(16'h0006, 16'h1234, "busy_rb");

        // Reset two cycles after an I read grant aborts it.
        i_enable = 1'b1;
        i_addr   = 16'h0002;
        tick();
        i_enable = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        snap = i_pulses;
        check("mrst_data", data_out, 0);
        check("mrst_iv", i_valid, 0);
        for (int k = 0; k < 5; k++) tick();
        check("mrst_no_pulse", i_pulses, snap);
        $display("txn reset mid-read");
        i_read(16'h0002, 16'h000E, "mrst_rb");

        // Totals: writes 3+1 and one data read; instruction reads
        // 8+3+1+1+1+1.
        tick();
        check("tot_d", d_pulses, 5);
        check("tot_i", i_pulses, 15);
        check("exclusive", both_seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cache_to_mem.md
CACHE_TO_MEM -- requirements
Module: cache_to_mem

Interface
REQ-001 SHALL have exactly one clock and one reset: reset is synchronous and active-high.
REQ-002 SHALL use the following ports, clock and reset first:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- d_enable  input  1  data-cache request (read miss or write).
- d_write  input  1  with d_enable: 1 = write, 0 = read.
- d_addr  input  16  data-side byte address.
- d_data  input  16  data-side write data.
- i_enable  input  1  instruction-cache read request.
- i_addr  input  16  instruction-side byte address.
- d_valid  output  1  one-cycle completion pulse for a data read or write.
- i_valid  output  1  one-cycle completion pulse for an instruction read.
- data_out  output  16  read data; qualified by d_valid (read) or i_valid.
REQ-003 SHALL use parameter MEM_WORDS, default 32768, meaning the backing-store depth in 16-bit words.

Function
REQ-004 SHALL own a single word-organised backing memory; word index = addr[15:1]; addr[0] ignored.
REQ-005 SHALL implement states IDLE, D_READ, I_READ, D_WRITE, with a 2-bit latency counter.
REQ-006 SHALL sample requests only in IDLE; a request in any other state waits and is not lost while its enable stays high.
REQ-007 SHALL give the data side priority: in IDLE with d_enable and i_enable both high, the data request is granted.
REQ-008 SHALL latch address, write data and direction at grant; later input changes do not affect the granted access.
REQ-009 SHALL handle reads granted at edge t0 as follows:
- data read from memory;
- data_out updated and d_valid/i_valid high for exactly the cycle between edges t0+3 and t0+4;
- return to IDLE at t0+4, where a new request can be sampled.
- Throughput: one 16-bit word per 4 cycles.
REQ-010 SHALL handle a write granted at edge t0 (d_enable & d_write) as follows:
- memory updated at t0;
- d_valid high for the cycle t0..t0+1, no read data;
- IDLE at t0+1.
REQ-011 SHALL hold data_out at its last value when no valid is asserted; data_out unchanged by writes.
REQ-012 SHALL never assert d_valid and i_valid in the same cycle.
REQ-013 SHALL treat enables deasserted before grant as no request; an enable dropping after grant does not abort the access.
REQ-014 SHALL make a read after a write to the same word return the written value.

Reset
REQ-015 SHALL, on rst high at a rising edge, set state to IDLE, counter to 0, d_valid = 0, i_valid = 0 and data_out = 16'h0000.
REQ-016 SHALL abort any in-flight access on reset mid-operation with no valid pulse; a write already committed stays committed.
REQ-017 SHALL NOT clear memory contents on reset; contents are 16'h0000 at simulation start.

Structure
REQ-018 SHALL place state encodings, READ_LATENCY = 4 and the word width in a shared cache_pkg package, reused by cache_fill_fsm.
REQ-019 SHALL instantiate one sub-module, multicycle_memory (single port, synchronous write, registered read, MEM_WORDS deep); the arbiter FSM and latency counter live in cache_to_mem.

Verification
REQ-020 SHALL pass these directed scenarios:
- Idle: after reset, no enables for 10 cycles -> d_valid = i_valid = 0, data_out = 0000.
- Instruction block fill: i_enable held; i_addr steps 0x0000, 0x0002 ... 0x000E after each i_valid -> exactly 8 i_valid pulses, first 4 cycles after the first grant, one every 4 cycles, d_valid never high.
- Write then read: write 000F@0x0000, 000E@0x0002, 000D@0x0004 -> d_valid pulse each, one cycle after grant.
  - Then i_enable reads of 0x0000/0x0002/0x0004 -> data_out = 000F/000E/000D with i_valid.
- Priority: d_enable read 0x0002 and i_enable 0x0004 raised the same cycle -> d_valid with 000E first; i_valid with 000D 4 cycles later.
- Busy deferral: d_enable write raised 1 cycle after an I read is granted -> write granted only at IDLE; i_valid and d_valid in distinct cycles.
- Reset mid-read: rst pulsed 2 cycles after an I read grant -> no i_valid, data_out = 0000, next read completes normally.
